// File: rtl/ring_monitor.sv
// ring_monitor: watches a one-hot ring counter and locks onto its sequence.
// Once locked it flags any broken advance with a sticky error and counts
// completed revolutions. All outputs come from registers, so each output
// describes the sample taken at the same clock edge.
module ring_monitor #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3,
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             adv,
    input  logic             clr_err,
    output logic [IW-1:0]    index,
    output logic             onehot,
    output logic             locked,
    output logic             err,
    output logic [7:0]       lap
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_streak;
    logic [3:0]       w_streak_next;
    logic [3:0]       w_streak_inc;
    logic [WIDTH-1:0] r_prev_q;

    logic             w_onehot;
    logic [IW-1:0]    w_index;
    logic [WIDTH-1:0] w_rot;
    logic             w_correct;
    logic             w_wrap;
    logic             w_fault;

    logic [IW-1:0]    w_index_next;
    logic             w_onehot_next;
    logic             w_locked_next;
    logic             w_err_next;
    logic [7:0]       w_lap_next;

    logic [IW-1:0]    r_index;
    logic             r_onehot;
    logic             r_locked;
    logic             r_err;
    logic [7:0]       r_lap;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);

    // Previous sample rotated left by one: the only legal successor when adv=1.
    assign w_rot = {r_prev_q[WIDTH-2:0], r_prev_q[WIDTH-1]};

    // A sample is correct if one-hot and it either advanced by exactly one
    // position or held still, matching what adv claims happened.
    assign w_correct = w_onehot && (adv ? (ring_in == w_rot) : (ring_in == r_prev_q));

    // Set bit moved from the top position back to bit 0: one revolution done.
    assign w_wrap = adv && r_prev_q[WIDTH-1] && ring_in[0];

    assign w_streak_inc = r_streak + 4'd1;

    // Binary position of the set bit; only meaningful when the sample is one-hot.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                w_index = IW'(i);
            end
        end
    end

    // State, streak and previous-sample registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= HUNT;
            r_streak <= 4'd0;
            r_prev_q <= '0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
            r_prev_q <= ring_in;
        end
    end

    // Next-state and streak logic.
    always_comb begin
        w_state_next  = r_state;
        w_streak_next = r_streak;
        case (r_state)
            HUNT: begin
                // Any one-hot sample is a candidate starting point; adv is ignored.
                if (w_onehot) begin
                    w_state_next  = CHECK;
                    w_streak_next = 4'd0;
                end
            end
            CHECK: begin
                if (!w_correct) begin
                    // Not locked yet, so a bad sample is not an error, just a restart.
                    w_state_next  = HUNT;
                    w_streak_next = 4'd0;
                end else if (adv) begin
                    w_streak_next = w_streak_inc;
                    if (w_streak_inc == 4'(LOCK_N)) begin
                        w_state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!w_correct) begin
                    w_state_next = FAULT;
                end
            end
            FAULT: begin
                // One-cycle pause, then start hunting again regardless of input.
                w_state_next  = HUNT;
                w_streak_next = 4'd0;
            end
            default: begin
                w_state_next  = HUNT;
                w_streak_next = 4'd0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_fault       = (r_state == LOCKED) && !w_correct;
        w_onehot_next = w_onehot;
        w_index_next  = w_onehot ? w_index : '0;
        w_locked_next = (w_state_next == LOCKED);
        // A new fault takes priority over a clear at the same edge.
        if (w_fault) begin
            w_err_next = 1'b1;
        end else if (clr_err) begin
            w_err_next = 1'b0;
        end else begin
            w_err_next = r_err;
        end
        // Laps only count while locked; the 8-bit counter wraps naturally.
        if ((r_state == LOCKED) && w_correct && w_wrap) begin
            w_lap_next = r_lap + 8'd1;
        end else begin
            w_lap_next = r_lap;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index  <= '0;
            r_onehot <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_lap    <= 8'd0;
        end else begin
            r_index  <= w_index_next;
            r_onehot <= w_onehot_next;
            r_locked <= w_locked_next;
            r_err    <= w_err_next;
            r_lap    <= w_lap_next;
        end
    end

    assign index  = r_index;
    assign onehot = r_onehot;
    assign locked = r_locked;
    assign err    = r_err;
    assign lap    = r_lap;

endmodule

// File: tb/tb_ring_monitor.sv
// Testbench for ring_monitor (WIDTH=4, LOCK_N=3): a table of directed
// vectors plus hand-written sequences for async reset and lap wrap.
module tb_ring_monitor;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       reset;
    logic [3:0] ring_in;
    logic       adv;
    logic       clr_err;
    logic [1:0] index;
    logic       onehot;
    logic       locked;
    logic       err;
    logic [7:0] lap;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] ring;
        logic       adv;
        logic       clr;
        logic [1:0] idx;
        logic       oh;
        logic       lk;
        logic       er;
        logic [7:0] lap;
    } vec_t;

    vec_t vecs[$];

    ring_monitor #(.WIDTH(4), .LOCK_N(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .ring_in (ring_in),
        .adv     (adv),
        .clr_err (clr_err),
        .index   (index),
        .onehot  (onehot),
        .locked  (locked),
        .err     (err),
        .lap     (lap)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic a, input logic c,
                       input logic [1:0] i, input logic o, input logic l,
                       input logic e, input logic [7:0] lp);
        vec_t v;
        v.ring = r; v.adv = a; v.clr = c;
        v.idx = i; v.oh = o; v.lk = l; v.er = e; v.lap = lp;
        vecs.push_back(v);
    endtask

    // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic cycle(input logic [3:0] r, input logic a, input logic c);
        @(negedge clk);
        ring_in = r; adv = a; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [1:0] i, input logic o,
                           input logic l, input logic e, input logic [7:0] lp);
        chk({tag, "_index"},  32'(index),  32'(i));
        chk({tag, "_onehot"}, 32'(onehot), 32'(o));
        chk({tag, "_locked"}, 32'(locked), 32'(l));
        chk({tag, "_err"},    32'(err),    32'(e));
        chk({tag, "_lap"},    32'(lap),    32'(lp));
    endtask

    initial begin
        ring_in = 4'b0000; adv = 1'b0; clr_err = 1'b0; reset = 1'b0;

        // Reset with the clock idle: outputs must clear without any edge.
        #2 reset = 1'b1;
        #3;
        chk_all("reset_idle", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        $display("txn reset_idle index=%0d onehot=%0b locked=%0b err=%0b lap=%0d", index, onehot, locked, err, lap);

        clk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        //   ring     adv   clr   idx  oh    lk    err   lap
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd0); // HUNT -> CHECK
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 8'd0); // streak 1
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 8'd0); // streak 2
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd0); // streak 3 -> LOCKED
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd1); // wrap -> lap 1
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd1);
        for (int k = 0; k < 5; k++)
            add(4'b0010, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd1); // hold while locked
        add(4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd1); // illegal -> FAULT
        add(4'b0110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'd1); // FAULT -> HUNT
        add(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd1); // HUNT -> CHECK, err sticky
        add(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd1); // clr_err clears
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 8'd1); // streak 1
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1); // streak 2, wrap not counted
        add(4'b0010, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 8'd1); // LOCKED
        add(4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 8'd1);
        add(4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 8'd1);
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 8'd2); // lap 2, at 0001
        add(4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'd2); // skip + clr: set wins
        add(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd2); // FAULT -> HUNT
        add(4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 8'd2); // HUNT -> CHECK
        add(4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'd2); // clear
        add(4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 8'd2); // bad in CHECK: no err
        add(4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2); // empty pattern
        add(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].ring, vecs[i].adv, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].idx, vecs[i].oh, vecs[i].lk, vecs[i].er, vecs[i].lap);
            $display("txn vec%0d ring=%b adv=%0b clr=%0b -> index=%0d onehot=%0b locked=%0b err=%0b lap=%0d",
                     i, vecs[i].ring, vecs[i].adv, vecs[i].clr, index, onehot, locked, err, lap);
        end

        // Async reset mid-lock with lap=5: first clear, lock, then run five revolutions.
        @(negedge clk); reset = 1'b1; ring_in = 4'b0000; adv = 1'b0;
        @(negedge clk); reset = 1'b0;
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            cycle(4'b0001, 1'b1, 1'b0);
            cycle(4'b0010, 1'b1, 1'b0);
            cycle(4'b0100, 1'b1, 1'b0);
            cycle(4'b1000, 1'b1, 1'b0);
        end
        chk("pre_reset_lap", 32'(lap), 32'd5);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        $display("txn pre_reset locked=%0b lap=%0d", locked, lap);

        @(negedge clk);
        #1 reset = 1'b1; ring_in = 4'b0000; adv = 1'b0;
        #1;
        chk_all("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        $display("txn async_reset index=%0d onehot=%0b locked=%0b err=%0b lap=%0d", index, onehot, locked, err, lap);
        reset = 1'b0;

        // Relock from scratch: history is gone, so three fresh advances are needed.
        cycle(4'b0001, 1'b1, 1'b0);
        chk_all("relock0", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle(4'b0010, 1'b1, 1'b0);
        chk_all("relock1", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle(4'b0100, 1'b1, 1'b0);
        chk_all("relock2", 2'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        cycle(4'b1000, 1'b1, 1'b0);
        chk_all("relock3", 2'd3, 1'b1, 1'b1, 1'b0, 8'd0);
        $display("txn relock locked=%0b lap=%0d", locked, lap);

        // Lap counter wrap: 255 revolutions, then one more returns to 0.
        for (int r = 0; r < 255; r++) begin
            cycle(4'b0001, 1'b1, 1'b0);
            cycle(4'b0010, 1'b1, 1'b0);
            cycle(4'b0100, 1'b1, 1'b0);
            cycle(4'b1000, 1'b1, 1'b0);
        end
        chk("lap_255", 32'(lap), 32'd255);
        $display("txn lap_255 lap=%0d locked=%0b", lap, locked);
        cycle(4'b0001, 1'b1, 1'b0);
        chk_all("lap_wrap", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
        $display("txn lap_wrap lap=%0d locked=%0b", lap, locked);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
